// File: rtl/dmem_resp_pkg.sv
// Shared types and defaults for the data-memory responder.
// Optional error detection is selected with the DMEM_RESP_ERR_EN macro in dmem_responder.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef logic [31:0] word_t;

    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port byte-lane word storage with synchronous, registered read.
// Storage is never reset; only the read register is.
module dmem_array
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     rd_i,
    input  logic                     clr_i,
    input  logic [3:0]               we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  word_t                    wdata_i,
    output word_t                    rdata_o
);

    logic [3:0][7:0] mem_q [DEPTH];
    word_t           rdata_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) mem_q[addr_i][i] <= wdata_i[8*i +: 8];
        end
    end

    // Read register holds across writes; an error response forces it to zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (rd_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: IDLE/WAIT/RESP FSM in front of dmem_array.
// Define DMEM_RESP_ERR_EN to flag out-of-range and read+write requests as errors.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_err
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(LATENCY + 1);
    localparam bit LAT1 = (LATENCY == 1);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   idx_q;
    word_t           wdata_q;
    logic [3:0]      be_q;
    logic            wr_q;
    logic            err_q;
    logic            resp_q;
    logic            resp_err_q;

    logic            req;
    logic            in_err;
    logic            in_idle;
    logic            go_resp;
    logic [AW-1:0]   cur_idx;
    word_t           cur_wdata;
    logic [3:0]      cur_be;
    logic            cur_wr;
    logic            cur_err;
    logic            arr_rd;
    logic            arr_clr;
    logic [3:0]      arr_we;
    logic            unused_addr_bits;

    assign req              = mem_read | mem_write;
    assign unused_addr_bits = ^mem_address;

`ifdef DMEM_RESP_ERR_EN
    assign in_err = ({2'b00, mem_address[31:2]} >= 32'(DEPTH)) | (mem_read & mem_write);
`else
    assign in_err = 1'b0;
`endif

    // With LATENCY=1 the storage access happens on the accept edge itself,
    // so the live inputs stand in for the not-yet-latched request.
    assign in_idle   = (state_q == IDLE);
    assign cur_idx   = in_idle ? mem_address[AW+1:2] : idx_q;
    assign cur_wdata = in_idle ? mem_wdata           : wdata_q;
    assign cur_be    = in_idle ? mem_byte_enable     : be_q;
    assign cur_wr    = in_idle ? mem_write           : wr_q;
    assign cur_err   = in_idle ? in_err              : err_q;

    assign go_resp = rst & ((LAT1 & in_idle & req) |
                            ((state_q == WAIT) & (cnt_q == CW'(1))));

    assign arr_rd  = go_resp & ~cur_err & ~cur_wr;
    assign arr_clr = go_resp & cur_err;
    assign arr_we  = (go_resp & ~cur_err & cur_wr) ? cur_be : 4'b0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            resp_q     <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_q     <= 1'b0;
                    resp_err_q <= 1'b0;
                    if (req) begin
                        idx_q   <= mem_address[AW+1:2];
                        wdata_q <= mem_wdata;
                        be_q    <= mem_byte_enable;
                        wr_q    <= mem_write;
                        err_q   <= in_err;
                        if (LAT1) begin
                            state_q    <= RESP;
                            resp_q     <= 1'b1;
                            resp_err_q <= in_err;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CW'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == CW'(1)) begin
                        state_q    <= RESP;
                        cnt_q      <= '0;
                        resp_q     <= 1'b1;
                        resp_err_q <= err_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    resp_q     <= 1'b0;
                    resp_err_q <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    resp_q     <= 1'b0;
                    resp_err_q <= 1'b0;
                end
            endcase
        end
    end

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk_i   (clk),
        .rst_n_i (rst),
        .rd_i    (arr_rd),
        .clr_i   (arr_clr),
        .we_i    (arr_we),
        .addr_i  (cur_idx),
        .wdata_i (cur_wdata),
        .rdata_o (mem_rdata)
    );

    assign mem_resp = resp_q;
    assign mem_err  = resp_err_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256: storage size in 32-bit words; power of two, at least 4.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to mem_resp; at least 1.
REQ-003 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous assertion, active-low (0 = in reset).
REQ-005 Port mem_address, input, 32: byte address; bits [1:0] are ignored.
REQ-006 Port mem_read, input, 1: read request, held by the initiator until mem_resp.
REQ-007 Port mem_write, input, 1: write request, held by the initiator until mem_resp.
REQ-008 Port mem_byte_enable, input, 4: write lane mask; bit i maps to wdata[8i+7:8i].
REQ-009 Port mem_wdata, input, 32: write data.
REQ-010 Port mem_rdata, output, 32: registered read data.
REQ-011 Port mem_resp, output, 1: single-cycle completion pulse.
REQ-012 Port mem_err, output, 1: error flag, valid only while mem_resp=1.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-014 IDLE with (mem_read | mem_write)=1 at a rising edge: accept; latch address, wdata, mask and operation; go to WAIT, or to RESP when LATENCY=1.
REQ-015 WAIT: a down-counter loaded with LATENCY-1 at accept decrements each cycle; at count 1 the next state is RESP.
REQ-016 mem_resp SHALL be 1 exactly during RESP; resp occurs in the LATENCY-th cycle after the accept edge.
REQ-017 RESP SHALL always return to IDLE on the next edge.
REQ-018 A request still high in the first IDLE cycle after RESP is a new request and is accepted; back-to-back throughput is one access per LATENCY+1 cycles.
REQ-019 Request input changes during WAIT or RESP SHALL be ignored; only latched values are used.
REQ-020 Read: mem_rdata SHALL load the addressed word on the edge entering RESP and hold it until the next read or error response.
REQ-021 Write: enabled byte lanes SHALL be updated on the edge entering RESP; mem_rdata is unchanged; mask 4'b0000 still responds with no storage change.
REQ-022 Word index SHALL be address[31:2]; a read in a later transaction SHALL return data from any preceding completed write.
REQ-023 mem_err SHALL be 0 on every non-error response.

Reset
REQ-024 While rst=0: state=IDLE, counter=0, mem_resp=0, mem_err=0, mem_rdata=32'h0.
REQ-025 Reset asserted mid-transaction SHALL abort it with no write and no mem_resp; storage contents are not cleared.
REQ-026 The first accept is possible at the first rising edge after rst deasserts.

Configuration
REQ-027 Macro DMEM_RESP_ERR_EN defined: error detection is enabled.
REQ-028 With DMEM_RESP_ERR_EN, a request is an error if address[31:2] >= DEPTH or mem_read & mem_write = 1.
REQ-029 An error request SHALL still take LATENCY cycles and respond with mem_resp=1, mem_err=1, mem_rdata=0 and no storage write.
REQ-030 Macro undefined: mem_err is tied 0; addresses wrap modulo DEPTH; read & write together is treated as a write.

Structure
REQ-031 Package dmem_resp_pkg SHALL hold the FSM state enum, the word type and the default DEPTH and LATENCY constants.
REQ-032 Byte-lane storage SHALL be a sub-module dmem_array: one port, byte write enables, synchronous read; the FSM and counter stay in dmem_responder.

Verification
REQ-033 LATENCY=2: write addr 0x10, data 0xDEADBEEF, mask 4'hF; then read 0x10 -> mem_resp pulses 2 cycles after each accept; read returns 0xDEADBEEF.
REQ-034 Mask 4'b0101 write of 0x11223344 over 0xDEADBEEF at 0x20, then read -> 0xDE22BE44.
REQ-035 Request held continuously for 3 transactions at LATENCY=1 -> mem_resp high on alternate cycles, 3 pulses.
REQ-036 rst=0 for one cycle in WAIT of a write to 0x30 -> no mem_resp; next read of 0x30 returns the prior contents.
REQ-037 DMEM_RESP_ERR_EN, DEPTH=256, read 0x400 -> mem_resp=1, mem_err=1, mem_rdata=0; without the macro -> data of word 0.
REQ-038 address[1:0]=2'b11 read of 0x13 -> returns word 0x10; mem_err=0.
